// File: rtl/rgb_wheel_pwm.sv
`timescale 1ns/1ps
// Purpose: N-LED common-anode RGB hue-wheel PWM driver sharing one hue engine, with brightness scaling.
// Latency: pins are registered one cycle after pc/shadow; duty changes land at the next period start.
// Backpressure: none; free-running outputs straight to the LED pins.
module rgb_wheel_pwm #(
    parameter int PWM_INTERVAL = 1200,
    parameter int SECTOR_STEPS = 200,
    parameter int STEP_CYCLES  = 12000,
    parameter int N_LEDS       = 1,
    localparam int H  = 6 * SECTOR_STEPS,
    localparam int HW = $clog2(H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [HW-1:0]     hue_in,
    input  logic [7:0]        brightness,
    output logic [N_LEDS-1:0] RGB_R,
    output logic [N_LEDS-1:0] RGB_G,
    output logic [N_LEDS-1:0] RGB_B,
    output logic              frame,
    output logic [HW-1:0]     hue_out
);

    localparam int PW        = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int DW        = $clog2(PWM_INTERVAL + 1);
    localparam int SW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int STEP_DUTY = PWM_INTERVAL / SECTOR_STEPS;
    localparam int OFS       = H / N_LEDS;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_CYCLE  = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_STATIC = 2'd3
    } mode_e;

    logic [PW-1:0] pc;
    logic [SW-1:0] sc;
    logic [HW-1:0] h;
    logic          pc_last;
    logic          sc_last;
    logic          h_last;
    logic          off;
    logic [HW-1:0] hue_clamped;

    assign pc_last     = (pc == PW'(PWM_INTERVAL - 1));
    assign sc_last     = (sc == SW'(STEP_CYCLES - 1));
    assign h_last      = (h == HW'(H - 1));
    assign off         = (mode_e'(mode) == MODE_OFF);
    assign hue_clamped = (hue_in > HW'(H - 1)) ? HW'(H - 1) : hue_in;
    assign hue_out     = h;

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] raw, input logic [7:0] b);
        return DW'(({8'd0, raw} * (DW+8)'({1'b0, b} + 9'd1)) >> 8);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            sc    <= '0;
            h     <= '0;
            frame <= 1'b0;
        end else begin
            frame <= pc_last;
            pc    <= pc_last ? '0 : pc + 1'b1;
            case (mode_e'(mode))
                MODE_CYCLE: begin
                    if (sc_last) begin
                        sc <= '0;
                        h  <= h_last ? '0 : h + 1'b1;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                MODE_STATIC: begin
                    sc <= '0;
                    h  <= hue_clamped;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        logic [HW:0]   hsum;
        logic [HW-1:0] hi;
        logic [2:0]    sector;
        logic [DW-1:0] up;
        logic [DW-1:0] dn;
        logic [DW-1:0] raw_r, raw_g, raw_b;
        logic [DW-1:0] sh_r, sh_g, sh_b;
        logic          pin_r, pin_g, pin_b;

        always_comb begin
            hsum   = {1'b0, h} + (HW+1)'(i * OFS);
            hi     = (hsum >= (HW+1)'(H)) ? HW'(hsum - (HW+1)'(H)) : hsum[HW-1:0];
            sector = 3'(hi / SECTOR_STEPS);
            up     = DW'((hi % SECTOR_STEPS) * STEP_DUTY);
            dn     = DW'(PWM_INTERVAL) - up;
            raw_r  = '0;
            raw_g  = '0;
            raw_b  = '0;
            case (sector)
                3'd0: begin raw_r = DW'(PWM_INTERVAL); raw_g = up; end
                3'd1: begin raw_r = dn; raw_g = DW'(PWM_INTERVAL); end
                3'd2: begin raw_g = DW'(PWM_INTERVAL); raw_b = up; end
                3'd3: begin raw_g = dn; raw_b = DW'(PWM_INTERVAL); end
                3'd4: begin raw_r = up; raw_b = DW'(PWM_INTERVAL); end
                3'd5: begin raw_r = DW'(PWM_INTERVAL); raw_b = dn; end
                default: ;
            endcase
        end

        // Shadows only reload on the last cycle of a period so each period's duty is stable.
        always_ff @(posedge clk) begin
            if (rst) begin
                sh_r  <= '0;
                sh_g  <= '0;
                sh_b  <= '0;
                pin_r <= 1'b1;
                pin_g <= 1'b1;
                pin_b <= 1'b1;
            end else begin
                if (pc_last) begin
                    sh_r <= scale(raw_r, brightness);
                    sh_g <= scale(raw_g, brightness);
                    sh_b <= scale(raw_b, brightness);
                end
                pin_r <= off | (DW'(pc) >= sh_r);
                pin_g <= off | (DW'(pc) >= sh_g);
                pin_b <= off | (DW'(pc) >= sh_b);
            end
        end

        assign RGB_R[i] = pin_r;
        assign RGB_G[i] = pin_g;
        assign RGB_B[i] = pin_b;
    end

endmodule

// File: tb/tb_rgb_wheel_pwm.sv
`timescale 1ns/1ps
// Directed bench for rgb_wheel_pwm: default-size, small-wheel and three-LED instances share one clock.
module tb_rgb_wheel_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]  mode_d;
    logic [10:0] hue_d;
    logic [7:0]  br_d;
    logic        r_d, g_d, b_d, frame_d;
    logic [10:0] hout_d;

    logic [1:0]  mode_s;
    logic [3:0]  hue_s;
    logic [7:0]  br_s;
    logic        r_s, g_s, b_s, frame_s;
    logic [3:0]  hout_s;

    logic [1:0]  mode_t;
    logic [10:0] hue_t;
    logic [7:0]  br_t;
    logic [2:0]  r_t, g_t, b_t;
    logic        frame_t;
    logic [10:0] hout_t;

    rgb_wheel_pwm u_def (
        .clk(clk), .rst(rst), .mode(mode_d), .hue_in(hue_d), .brightness(br_d),
        .RGB_R(r_d), .RGB_G(g_d), .RGB_B(b_d), .frame(frame_d), .hue_out(hout_d)
    );

    rgb_wheel_pwm #(.PWM_INTERVAL(12), .SECTOR_STEPS(2), .STEP_CYCLES(4), .N_LEDS(1)) u_sm (
        .clk(clk), .rst(rst), .mode(mode_s), .hue_in(hue_s), .brightness(br_s),
        .RGB_R(r_s), .RGB_G(g_s), .RGB_B(b_s), .frame(frame_s), .hue_out(hout_s)
    );

    rgb_wheel_pwm #(.N_LEDS(3)) u_tri (
        .clk(clk), .rst(rst), .mode(mode_t), .hue_in(hue_t), .brightness(br_t),
        .RGB_R(r_t), .RGB_G(g_t), .RGB_B(b_t), .frame(frame_t), .hue_out(hout_t)
    );

    int n_checks = 0;
    int n_fail   = 0;
    string exp_tag[$];
    int    exp_val[$];

    int lr, lg, lb;
    int cnt_t[9];
    int exp_t0[9] = '{1200, 0, 0, 0, 1200, 0, 0, 0, 1200};
    int exp_t1[9] = '{1200, 600, 0, 0, 1200, 600, 600, 0, 1200};

    task automatic expect_v(input string tag, input int v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic check(input int obs);
        string tag;
        int    v;
        n_checks++;
        if (exp_val.size() == 0) begin
            tag = "empty_scoreboard";
            v   = -1;
        end else begin
            tag = exp_tag.pop_front();
            v   = exp_val.pop_front();
        end
        assert (obs === v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, v);
        end
    endtask

    task automatic bound_ok(input logic ok, input string tag);
        n_checks++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    task automatic wait_frame_d();
        int g = 0;
        do begin @(negedge clk); g++; end while (!frame_d && g < 3000);
        bound_ok(frame_d, "frame_d_wait");
    endtask

    // Starts counting on the current frame cycle if already in it; counts 1200 low samples per channel.
    task automatic measure_d(input int chg_at, input logic [10:0] chg_hue);
        int g = 0;
        while (!frame_d && g < 3000) begin @(negedge clk); g++; end
        bound_ok(frame_d, "frame_d_measure");
        lr = 0; lg = 0; lb = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!r_d) lr++;
            if (!g_d) lg++;
            if (!b_d) lb++;
            if (i == chg_at) hue_d = chg_hue;
        end
    endtask

    task automatic def_static(input logic [10:0] hue, input logic [7:0] br,
                              input int er, input int eg, input int eb, input string tag);
        mode_d = 2'd3;
        hue_d  = hue;
        br_d   = br;
        expect_v({tag, "_r"}, er);
        expect_v({tag, "_g"}, eg);
        expect_v({tag, "_b"}, eb);
        wait_frame_d();
        wait_frame_d();
        measure_d(-1, hue);
        check(lr);
        check(lg);
        check(lb);
    endtask

    task automatic wait_frame_t();
        int g = 0;
        do begin @(negedge clk); g++; end while (!frame_t && g < 3000);
        bound_ok(frame_t, "frame_t_wait");
    endtask

    task automatic measure_t();
        int g = 0;
        while (!frame_t && g < 3000) begin @(negedge clk); g++; end
        bound_ok(frame_t, "frame_t_measure");
        for (int j = 0; j < 9; j++) cnt_t[j] = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (!r_t[j]) cnt_t[3*j]++;
                if (!g_t[j]) cnt_t[3*j+1]++;
                if (!b_t[j]) cnt_t[3*j+2]++;
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int cnt, p, bad, sum;
        logic [2:0] prev_pins;
        logic       prev_frame;

        rst    = 1'b1;
        mode_d = 2'd3; hue_d = 11'd100; br_d = 8'd255;
        mode_s = 2'd1; hue_s = 4'd0;    br_s = 8'd255;
        mode_t = 2'd3; hue_t = 11'd0;   br_t = 8'd255;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset mid-period with lit LEDs and a non-zero hue.
        repeat (1500) @(negedge clk);
        mode_d = 2'd1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_v("rst_pins", 7);
        expect_v("rst_frame", 0);
        expect_v("rst_hue_out", 0);
        expect_v("rst_tri_pins", 511);
        check(int'({r_d, g_d, b_d}));
        check(int'(frame_d));
        check(int'(hout_d));
        check(int'({r_t, g_t, b_t}));
        rst = 1'b0;
        expect_v("first_frame_gap", 1200);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!frame_d && cnt < 5000);
        check(cnt);

        def_static(11'd100,  8'd255, 1200, 600, 0, "s100");
        def_static(11'd1199, 8'd255, 1200, 0,   6, "s1199");
        def_static(11'd2000, 8'd255, 1200, 0,   6, "sclamp");
        expect_v("clamp_hue_out", 1199);
        check(int'(hout_d));
        def_static(11'd100,  8'd127, 600,  300, 0, "b127");
        def_static(11'd100,  8'd0,   4,    2,   0, "b0");
        def_static(11'd100,  8'd255, 1200, 600, 0, "s100b");

        // Mid-period hue change must not disturb the running period.
        expect_v("glitch_cur_r", 1200);
        expect_v("glitch_cur_g", 600);
        expect_v("glitch_cur_b", 0);
        measure_d(300, 11'd300);
        check(lr); check(lg); check(lb);
        expect_v("glitch_next_r", 600);
        expect_v("glitch_next_g", 1200);
        expect_v("glitch_next_b", 0);
        measure_d(-1, 11'd300);
        check(lr); check(lg); check(lb);

        // Small wheel in CYCLE mode: one step every 4 cycles, 11 wraps to 0.
        p = int'(hout_s);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (int'(hout_s) == p && cnt < 20);
        bound_ok(int'(hout_s) != p, "sm_first_step");
        for (int k = 0; k < 14; k++) begin
            p = int'(hout_s);
            expect_v("sm_step_val", (p + 1) % 12);
            expect_v("sm_step_gap", 4);
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (int'(hout_s) == p && cnt < 20);
            check(int'(hout_s));
            check(cnt);
        end
        // A pin may only start a low phase on the cycle right after a frame pulse.
        bad = 0;
        prev_pins  = {r_s, g_s, b_s};
        prev_frame = frame_s;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++)
                if (prev_pins[j] && !({r_s, g_s, b_s} >> j & 3'd1) && !prev_frame) bad++;
            prev_pins  = {r_s, g_s, b_s};
            prev_frame = frame_s;
        end
        expect_v("sm_midperiod_fall", 0);
        check(bad);

        // Three LEDs spaced 400 hue steps apart.
        wait_frame_t();
        wait_frame_t();
        measure_t();
        for (int j = 0; j < 9; j++) expect_v($sformatf("tri_h0_%0d", j), exp_t0[j]);
        for (int j = 0; j < 9; j++) check(cnt_t[j]);

        hue_t = 11'd100;
        wait_frame_t();
        wait_frame_t();
        measure_t();
        for (int j = 0; j < 9; j++) expect_v($sformatf("tri_h100_%0d", j), exp_t1[j]);
        for (int j = 0; j < 9; j++) check(cnt_t[j]);

        repeat (300) @(negedge clk);
        mode_t = 2'd0;
        hue_t  = 11'd50;
        @(negedge clk);
        expect_v("off_pins_now", 511);
        check(int'({r_t, g_t, b_t}));
        repeat (50) @(negedge clk);
        expect_v("off_hue_held", 100);
        check(int'(hout_t));
        measure_t();
        sum = 0;
        for (int j = 0; j < 9; j++) sum += cnt_t[j];
        expect_v("off_lows", 0);
        check(sum);

        repeat (300) @(negedge clk);
        mode_t = 2'd2;
        @(negedge clk);
        expect_v("exit_off_pins_now", 0);
        check(int'({r_t[0], g_t[1], b_t[2]}));
        measure_t();
        for (int j = 0; j < 9; j++) expect_v($sformatf("tri_resume_%0d", j), exp_t1[j]);
        for (int j = 0; j < 9; j++) check(cnt_t[j]);
        expect_v("resume_hue", 100);
        check(int'(hout_t));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
